// File: rtl/mips_pc_pkg.sv
// Shared types and default vectors for the fetch-stage PC sequencer.
package mips_pc_pkg;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_EXC
  } pc_state_e;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_HOLD,
    SEL_BR,
    SEL_JMP,
    SEL_EXC,
    SEL_ERET
  } pc_sel_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0180;
  localparam logic [31:0] DEF_PC_INC       = 32'd4;

  function automatic logic is_redirect(input pc_sel_e sel);
    return (sel != SEL_SEQ) && (sel != SEL_HOLD);
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Priority next-PC select with word-alignment check on branch/jump/eret targets.
module pc_next_mux
  import mips_pc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
  parameter logic [31:0] PC_INC     = DEF_PC_INC
) (
  input  logic        exc_req_i,
  input  logic        eret_i,
  input  logic        branch_taken_i,
  input  logic        jump_i,
  input  logic        stall_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] epc_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] jump_target_i,
  output pc_sel_e     sel_o,
  output logic [31:0] next_pc_o,
  output logic        misalign_o
);

  logic [31:0] target;
  logic        use_target;

  always_comb begin
    sel_o      = SEL_SEQ;
    target     = '0;
    use_target = 1'b0;
    next_pc_o  = pc_i + PC_INC;
    misalign_o = 1'b0;

    if (exc_req_i) begin
      sel_o     = SEL_EXC;
      next_pc_o = EXC_VECTOR;
    end else if (eret_i) begin
      sel_o      = SEL_ERET;
      target     = epc_i;
      use_target = 1'b1;
    end else if (branch_taken_i) begin
      sel_o      = SEL_BR;
      target     = branch_target_i;
      use_target = 1'b1;
    end else if (jump_i) begin
      sel_o      = SEL_JMP;
      target     = jump_target_i;
      use_target = 1'b1;
    end else if (stall_i) begin
      sel_o     = SEL_HOLD;
      next_pc_o = pc_i;
    end

    // Targets are loaded word-aligned; low bits only raise the error flag.
    if (use_target) begin
      next_pc_o  = {target[31:2], 2'b00};
      misalign_o = |target[1:0];
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: boot/run/exception FSM with PC, EPC and AlignErr registers.
module pc_sequencer
  import mips_pc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR,
  parameter logic [31:0] PC_INC       = DEF_PC_INC
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        ExcReq,
  input  logic [31:0] ExcPC,
  input  logic        Eret,
  output logic [31:0] PC,
  output logic        FetchValid,
  output logic        FlushIF,
  output logic [31:0] EPC,
  output logic        AlignErr
);

  pc_state_e   state_q;
  logic [31:0] pc_q;
  logic [31:0] epc_q;
  logic        fetch_valid_q;
  logic        align_err_q;

  pc_sel_e     sel_d;
  logic [31:0] pc_d;
  logic        misalign_d;

  pc_next_mux #(
    .EXC_VECTOR (EXC_VECTOR),
    .PC_INC     (PC_INC)
  ) u_next_mux (
    .exc_req_i       (ExcReq),
    .eret_i          (Eret),
    .branch_taken_i  (BranchTaken),
    .jump_i          (Jump),
    .stall_i         (Stall),
    .pc_i            (pc_q),
    .epc_i           (epc_q),
    .branch_target_i (BranchTarget),
    .jump_target_i   (JumpTarget),
    .sel_o           (sel_d),
    .next_pc_o       (pc_d),
    .misalign_o      (misalign_d)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_VECTOR;
      epc_q         <= '0;
      fetch_valid_q <= 1'b0;
      align_err_q   <= 1'b0;
    end else begin
      align_err_q <= 1'b0;
      case (state_q)
        S_BOOT: begin
          state_q       <= S_RUN;
          fetch_valid_q <= 1'b1;
        end
        S_RUN: begin
          pc_q        <= pc_d;
          align_err_q <= misalign_d;
          if (sel_d == SEL_EXC) begin
            epc_q         <= ExcPC;
            state_q       <= S_EXC;
            fetch_valid_q <= 1'b0;
          end
        end
        S_EXC: begin
          state_q       <= S_RUN;
          fetch_valid_q <= 1'b1;
        end
        default: begin
          state_q       <= S_BOOT;
          pc_q          <= RESET_VECTOR;
          fetch_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign PC         = pc_q;
  assign EPC        = epc_q;
  assign FetchValid = fetch_valid_q;
  assign AlignErr   = align_err_q;
  assign FlushIF    = (state_q == S_EXC) ||
                      ((state_q == S_RUN) && is_redirect(sel_d));

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic        ExcReq;
  logic [31:0] ExcPC;
  logic        Eret;
  logic [31:0] PC;
  logic        FetchValid;
  logic        FlushIF;
  logic [31:0] EPC;
  logic        AlignErr;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  pc_sequencer #(
    .RESET_VECTOR (32'h0000_0000),
    .EXC_VECTOR   (32'h0000_0180),
    .PC_INC       (32'd4)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Stall        (Stall),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .Jump         (Jump),
    .JumpTarget   (JumpTarget),
    .ExcReq       (ExcReq),
    .ExcPC        (ExcPC),
    .Eret         (Eret),
    .PC           (PC),
    .FetchValid   (FetchValid),
    .FlushIF      (FlushIF),
    .EPC          (EPC),
    .AlignErr     (AlignErr)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    Stall        = 1'b0;
    BranchTaken  = 1'b0;
    BranchTarget = '0;
    Jump         = 1'b0;
    JumpTarget   = '0;
    ExcReq       = 1'b0;
    ExcPC        = '0;
    Eret         = 1'b0;
  endtask

  task automatic jump_to(input logic [31:0] tgt);
    Jump       = 1'b1;
    JumpTarget = tgt;
    step();
    Jump       = 1'b0;
  endtask

  initial begin
    Reset_n = 1'b0;
    clear_inputs();
    step();
    step();
    check("rst_pc",    PC,         32'h0);
    check("rst_fv",    FetchValid, 32'h0);
    check("rst_flush", FlushIF,    32'h0);
    check("rst_align", AlignErr,   32'h0);
    check("rst_epc",   EPC,        32'h0);

    // Boot: inputs ignored, one invalid cycle at RESET_VECTOR.
    Reset_n     = 1'b1;
    BranchTaken = 1'b1;
    BranchTarget = 32'h0000_0999;
    #1;
    check("boot_pc",    PC,         32'h0);
    check("boot_fv",    FetchValid, 32'h0);
    check("boot_flush", FlushIF,    32'h0);
    step();
    clear_inputs();
    check("run0_pc", PC,         32'h0);
    check("run0_fv", FetchValid, 32'h1);
    step(); check("seq_4", PC, 32'h4);
    step(); check("seq_8", PC, 32'h8);
    step(); step();
    check("seq_10", PC, 32'h10);

    // Stall holds; redirect overrides stall.
    Stall = 1'b1;
    step(); check("stall1", PC, 32'h10);
    step(); check("stall2", PC, 32'h10);
    check("stall_noflush", FlushIF, 32'h0);
    BranchTaken  = 1'b1;
    BranchTarget = 32'h40;
    #1;
    check("br_flush", FlushIF, 32'h1);
    step();
    clear_inputs();
    check("br_pc",    PC,       32'h40);
    check("br_align", AlignErr, 32'h0);

    // Exception beats simultaneous branch.
    jump_to(32'h20);
    check("pre_exc_pc", PC, 32'h20);
    ExcReq       = 1'b1;
    ExcPC        = 32'h1C;
    BranchTaken  = 1'b1;
    BranchTarget = 32'h80;
    #1;
    check("exc_flush", FlushIF, 32'h1);
    step();
    // Still asserting ExcReq with a different PC during the drain bubble.
    ExcPC = 32'h55;
    Stall = 1'b1;
    Eret  = 1'b1;
    check("exc_pc",    PC,         32'h180);
    check("exc_epc",   EPC,        32'h1C);
    check("exc_fv",    FetchValid, 32'h0);
    check("exc_flush2", FlushIF,   32'h1);
    step();
    clear_inputs();
    check("exc_nest_epc", EPC,        32'h1C);
    check("exc_run_pc",   PC,         32'h180);
    check("exc_run_fv",   FetchValid, 32'h1);
    step();
    check("exc_seq", PC, 32'h184);

    // Return from exception.
    Eret = 1'b1;
    #1;
    check("eret_flush", FlushIF, 32'h1);
    step();
    Eret = 1'b0;
    check("eret_pc",  PC,  32'h1C);
    check("eret_epc", EPC, 32'h1C);

    // Misaligned jump target.
    jump_to(32'h103);
    check("jmp_align_pc",  PC,       32'h100);
    check("jmp_align_err", AlignErr, 32'h1);
    step();
    check("jmp_align_clr", AlignErr, 32'h0);
    check("jmp_align_seq", PC,       32'h104);

    // Misaligned branch target also flagged.
    BranchTaken  = 1'b1;
    BranchTarget = 32'h0000_0302;
    step();
    BranchTaken = 1'b0;
    check("br_align_pc",  PC,       32'h300);
    check("br_align_err", AlignErr, 32'h1);

    // Wrap-around.
    jump_to(32'hFFFF_FFFC);
    check("wrap_pre", PC, 32'hFFFF_FFFC);
    step();
    check("wrap_pc", PC, 32'h0);

    // Async reset between edges.
    jump_to(32'h200);
    check("pre_rst_pc", PC, 32'h200);
    #2;
    Reset_n = 1'b0;
    #1;
    check("arst_pc",  PC,         32'h0);
    check("arst_fv",  FetchValid, 32'h0);
    check("arst_epc", EPC,        32'h0);
    step();
    check("arst_hold", PC, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
